// File: rtl/s27_test_pkg.sv
// rtl/s27_test_pkg.sv - shared types and defaults for the s27 scan test controller
package s27_test_pkg;

  // Default geometry of the s27 benchmark and its result counters
  localparam int unsigned DEF_SCAN_LEN = 3;
  localparam int unsigned DEF_PI_W     = 4;
  localparam int unsigned DEF_CNT_W    = 8;

  // Pattern sequencing states
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CAPTURE = 3'd2,
    S_UNLOAD  = 3'd3,
    S_DONE    = 3'd4
  } scan_state_e;

  // Width of the shift step counter; never narrower than one bit
  function automatic int unsigned step_width(input int unsigned len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/s27_scan.sv
// rtl/s27_scan.sv - ISCAS89 s27 core with a scan mux in front of each flip-flop
module s27_scan (
  input  logic CK,
  input  logic SE,
  input  logic SI,
  input  logic G0,
  input  logic G1,
  input  logic G2,
  input  logic G3,
  output logic SO,
  output logic G17
);

  // Supply rails of the original netlist, tied off here
  logic gnd;
  logic vdd;
  assign gnd = 1'b0;
  assign vdd = 1'b1;

  // Core state: G5 = DFF_0, G6 = DFF_1, G7 = DFF_2
  logic g5_q;
  logic g6_q;
  logic g7_q;

  logic g8, g9, g10, g11, g12, g13, g14, g15, g16;

  // Combinational s27 netlist
  assign g14 = ~G0;
  assign g8  = g14 & g6_q & vdd;
  assign g12 = ~(G1 | g7_q);
  assign g15 = g12 | g8 | gnd;
  assign g16 = G3 | g8;
  assign g9  = ~(g16 & g15);
  assign g11 = ~(g5_q | g9);
  assign g10 = ~(g14 | g11);
  assign g13 = ~(G2 | g12);
  assign G17 = ~g11;

  // Scan-out taps the last flip-flop of the chain
  assign SO = g7_q;

  // Each flop takes its chain predecessor when SE=1, its functional D-input otherwise
  always_ff @(posedge CK) begin
    g5_q <= SE ? SI   : g10;
    g6_q <= SE ? g5_q : g11;
    g7_q <= SE ? g6_q : g13;
  end

endmodule

// File: rtl/s27_scan_ctrl.sv
// rtl/s27_scan_ctrl.sv - applies one scan pattern to s27 and scores the response
module s27_scan_ctrl
  import s27_test_pkg::*;
#(
  parameter int unsigned SCAN_LEN = DEF_SCAN_LEN,
  parameter int unsigned PI_W     = DEF_PI_W,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic                CK,
  input  logic                RST,
  input  logic                START,
  output logic                READY,
  input  logic [SCAN_LEN-1:0] PAT_ST,
  input  logic [PI_W-1:0]     PAT_PI,
  input  logic [SCAN_LEN-1:0] EXP_ST,
  input  logic                EXP_PO,
  input  logic [SCAN_LEN:0]   EXP_MASK,
  input  logic                CLR,
  output logic                DONE,
  output logic                PASS,
  output logic [CNT_W-1:0]    PAT_CNT,
  output logic [CNT_W-1:0]    FAIL_CNT
);

  localparam int unsigned           STEP_W    = step_width(SCAN_LEN);
  localparam logic [STEP_W-1:0]     LAST_STEP = STEP_W'(SCAN_LEN - 1);

  scan_state_e         state_q;
  logic [STEP_W-1:0]   step_q;

  // Latched pattern; the state-side vectors are consumed MSB-first by shifting
  logic [SCAN_LEN-1:0] load_sh_q;
  logic [SCAN_LEN-1:0] exp_sh_q;
  logic [SCAN_LEN-1:0] mask_sh_q;
  logic [PI_W-1:0]     pi_q;
  logic                exp_po_q;
  logic                mask_po_q;

  logic                fail_q;
  logic                ready_q;
  logic                done_q;
  logic                pass_q;
  logic [CNT_W-1:0]    pat_cnt_q;
  logic [CNT_W-1:0]    fail_cnt_q;

  logic                se;
  logic                si;
  logic                so;
  logic                g17;
  logic                po_miss;
  logic                so_miss;

  // Scan enable only while shifting; SI feeds the pattern during LOAD and zeros during UNLOAD
  assign se = (state_q == S_LOAD) || (state_q == S_UNLOAD);
  assign si = (state_q == S_LOAD) ? load_sh_q[SCAN_LEN-1] : 1'b0;

  // Masked comparisons: PO during CAPTURE, scan-out during each UNLOAD step
  assign po_miss = mask_po_q && (g17 != exp_po_q);
  assign so_miss = mask_sh_q[SCAN_LEN-1] && (so != exp_sh_q[SCAN_LEN-1]);

  s27_scan u_core (
    .CK  (CK),
    .SE  (se),
    .SI  (si),
    .G0  (pi_q[0]),
    .G1  (pi_q[1]),
    .G2  (pi_q[2]),
    .G3  (pi_q[3]),
    .SO  (so),
    .G17 (g17)
  );

  // Pattern sequencer with registered handshake, result and counter outputs
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      step_q     <= '0;
      load_sh_q  <= '0;
      exp_sh_q   <= '0;
      mask_sh_q  <= '0;
      pi_q       <= '0;
      exp_po_q   <= 1'b0;
      mask_po_q  <= 1'b0;
      fail_q     <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      pat_cnt_q  <= '0;
      fail_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            load_sh_q <= PAT_ST;
            exp_sh_q  <= EXP_ST;
            mask_sh_q <= EXP_MASK[SCAN_LEN-1:0];
            mask_po_q <= EXP_MASK[SCAN_LEN];
            exp_po_q  <= EXP_PO;
            pi_q      <= PAT_PI;
            fail_q    <= 1'b0;
            step_q    <= '0;
            ready_q   <= 1'b0;
            state_q   <= S_LOAD;
          end
        end
        S_LOAD: begin
          load_sh_q <= load_sh_q << 1;
          if (step_q == LAST_STEP) begin
            step_q  <= '0;
            state_q <= S_CAPTURE;
          end else begin
            step_q <= step_q + 1'b1;
          end
        end
        S_CAPTURE: begin
          if (po_miss) begin
            fail_q <= 1'b1;
          end
          state_q <= S_UNLOAD;
        end
        S_UNLOAD: begin
          if (so_miss) begin
            fail_q <= 1'b1;
          end
          exp_sh_q  <= exp_sh_q << 1;
          mask_sh_q <= mask_sh_q << 1;
          if (step_q == LAST_STEP) begin
            step_q  <= '0;
            state_q <= S_DONE;
          end else begin
            step_q <= step_q + 1'b1;
          end
        end
        S_DONE: begin
          done_q    <= 1'b1;
          pass_q    <= ~fail_q;
          pat_cnt_q <= pat_cnt_q + 1'b1;
          if (fail_q && (fail_cnt_q != {CNT_W{1'b1}})) begin
            fail_cnt_q <= fail_cnt_q + 1'b1;
          end
          ready_q   <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
      // Clear overrides any count taken on the same edge
      if (CLR) begin
        pat_cnt_q  <= '0;
        fail_cnt_q <= '0;
      end
    end
  end

  assign READY    = ready_q;
  assign DONE     = done_q;
  assign PASS     = pass_q;
  assign PAT_CNT  = pat_cnt_q;
  assign FAIL_CNT = fail_cnt_q;

endmodule

// File: tb/tb_s27_scan_ctrl.sv
// tb/tb_s27_scan_ctrl.sv - directed self-checking bench for s27_scan_ctrl
module tb_s27_scan_ctrl;

  logic       ck;
  logic       rst;
  logic       start;
  logic       ready;
  logic [2:0] pat_st;
  logic [3:0] pat_pi;
  logic [2:0] exp_st;
  logic       exp_po;
  logic [3:0] exp_mask;
  logic       clr;
  logic       done;
  logic       pass;
  logic [7:0] pat_cnt;
  logic [7:0] fail_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] st;
    logic [3:0] pi;
    logic [2:0] xst;
    logic       xpo;
    logic [3:0] mask;
    logic       pass;
  } vec_t;

  vec_t       vecs[12];
  logic [7:0] m_pat;
  logic [7:0] m_fail;

  s27_scan_ctrl dut (
    .CK       (ck),
    .RST      (rst),
    .START    (start),
    .READY    (ready),
    .PAT_ST   (pat_st),
    .PAT_PI   (pat_pi),
    .EXP_ST   (exp_st),
    .EXP_PO   (exp_po),
    .EXP_MASK (exp_mask),
    .CLR      (clr),
    .DONE     (done),
    .PASS     (pass),
    .PAT_CNT  (pat_cnt),
    .FAIL_CNT (fail_cnt)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic drive_vec(input vec_t v);
    pat_st   = v.st;
    pat_pi   = v.pi;
    exp_st   = v.xst;
    exp_po   = v.xpo;
    exp_mask = v.mask;
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  // Waits for READY, issues one START, returns PASS and edges from acceptance to DONE
  task automatic run_pat(input vec_t v, output logic got_pass, output int lat);
    int w;
    w = 0;
    while (ready !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    drive_vec(v);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    got_pass = pass;
  endtask

  task automatic model_done(input logic p);
    m_pat = m_pat + 8'd1;
    if (!p && m_fail != 8'hff) m_fail = m_fail + 8'd1;
  endtask

  initial begin
    logic       gp;
    int         lat;
    int         n_done, first, last, gap_bad, rdy_bad, cnt_bad, saw_done, bad_runs;
    logic [7:0] prev;

    vecs[0]  = '{3'b000, 4'b0000, 3'b000, 1'b1, 4'b1111, 1'b1};
    vecs[1]  = '{3'b010, 4'b0000, 3'b010, 1'b0, 4'b1111, 1'b1};
    vecs[2]  = '{3'b010, 4'b0000, 3'b010, 1'b1, 4'b1111, 1'b0};
    vecs[3]  = '{3'b010, 4'b0000, 3'b010, 1'b1, 4'b0111, 1'b1};
    vecs[4]  = '{3'b111, 4'b1111, 3'b001, 1'b1, 4'b1111, 1'b1};
    vecs[5]  = '{3'b111, 4'b1111, 3'b000, 1'b1, 4'b1111, 1'b0};
    vecs[6]  = '{3'b001, 4'b0001, 3'b101, 1'b1, 4'b1111, 1'b0};
    vecs[7]  = '{3'b001, 4'b0001, 3'b101, 1'b1, 4'b1011, 1'b1};
    vecs[8]  = '{3'b100, 4'b0110, 3'b000, 1'b1, 4'b1111, 1'b1};
    vecs[9]  = '{3'b000, 4'b1000, 3'b010, 1'b0, 4'b1111, 1'b1};
    vecs[10] = '{3'b000, 4'b1000, 3'b000, 1'b0, 4'b1111, 1'b0};
    vecs[11] = '{3'b000, 4'b0000, 3'b111, 1'b0, 4'b0000, 1'b1};

    rst = 1'b1; start = 1'b0; clr = 1'b0;
    pat_st = '0; pat_pi = '0; exp_st = '0; exp_po = 1'b0; exp_mask = '0;
    m_pat = 8'd0; m_fail = 8'd0;

    #12;
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_pat_cnt", pat_cnt, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    rst = 1'b0;

    // Table-driven patterns
    for (int i = 0; i < 12; i++) begin
      run_pat(vecs[i], gp, lat);
      model_done(vecs[i].pass);
      check($sformatf("vec%0d_latency", i), lat, 8);
      check($sformatf("vec%0d_pass", i), gp, vecs[i].pass);
      check($sformatf("vec%0d_pat_cnt", i), pat_cnt, m_pat);
      check($sformatf("vec%0d_fail_cnt", i), fail_cnt, m_fail);
      check($sformatf("vec%0d_ready_on_done", i), ready, 1);
      tick();
      check($sformatf("vec%0d_done_pulse", i), done, 0);
    end

    // START held high: one acceptance per IDLE cycle, DONE every 9 cycles
    drive_vec(vecs[0]);
    start = 1'b1;
    n_done = 0; first = 0; last = 0; gap_bad = 0; rdy_bad = 0; cnt_bad = 0;
    prev = m_pat;
    for (int i = 1; i <= 36; i++) begin
      tick();
      if (ready !== done) rdy_bad++;
      if (done === 1'b1) begin
        n_done++;
        if (n_done == 1) first = i;
        else if (i - last != 9) gap_bad++;
        last = i;
        prev = prev + 8'd1;
        if (pat_cnt !== prev) cnt_bad++;
      end
    end
    start = 1'b0;
    for (int i = 0; i < 4; i++) model_done(1'b1);
    check("hold_done_count", n_done, 4);
    check("hold_first_done", first, 9);
    check("hold_gap_errors", gap_bad, 0);
    check("hold_ready_only_idle", rdy_bad, 0);
    check("hold_cnt_step_errors", cnt_bad, 0);
    check("hold_pat_cnt", pat_cnt, m_pat);

    // Reset pulse during UNLOAD step 1 aborts the pattern
    drive_vec(vecs[0]);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("midrst_ready", ready, 1);
    check("midrst_done", done, 0);
    check("midrst_pat_cnt", pat_cnt, 0);
    check("midrst_fail_cnt", fail_cnt, 0);
    #2;
    rst = 1'b0;
    m_pat = 8'd0; m_fail = 8'd0;
    tick();
    check("midrst_ready_after", ready, 1);
    saw_done = 0;
    repeat (12) begin
      tick();
      if (done === 1'b1) saw_done++;
    end
    check("midrst_no_done", saw_done, 0);
    check("midrst_pat_cnt_after", pat_cnt, 0);
    run_pat(vecs[0], gp, lat);
    model_done(1'b1);
    check("post_rst_latency", lat, 8);
    check("post_rst_pass", gp, 1);
    check("post_rst_pat_cnt", pat_cnt, m_pat);

    // CLR on the DONE edge wins over the count
    run_pat(vecs[2], gp, lat);
    model_done(1'b0);
    check("pre_clr_fail_cnt", fail_cnt, m_fail);
    tick();
    drive_vec(vecs[2]);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    clr = 1'b1;
    tick();
    check("clr_done_seen", done, 1);
    check("clr_done_pat_cnt", pat_cnt, 0);
    check("clr_done_fail_cnt", fail_cnt, 0);
    clr = 1'b0;
    tick();
    check("clr_after_pat_cnt", pat_cnt, 0);
    check("clr_after_fail_cnt", fail_cnt, 0);
    m_pat = 8'd0; m_fail = 8'd0;

    // 256 failing patterns: PAT_CNT wraps, FAIL_CNT saturates
    bad_runs = 0;
    for (int i = 0; i < 256; i++) begin
      run_pat(vecs[2], gp, lat);
      model_done(1'b0);
      if (gp !== 1'b0 || lat != 8) bad_runs++;
    end
    check("sat_bad_runs", bad_runs, 0);
    check("sat_pat_cnt", pat_cnt, m_pat);
    check("sat_pat_cnt_wrapped", pat_cnt, 0);
    check("sat_fail_cnt", fail_cnt, 255);

    // Plain clear outside a pattern
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_idle_pat_cnt", pat_cnt, 0);
    check("clr_idle_fail_cnt", fail_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
